qr_stage_sequencer: RTL

//  Top-level sequencer for the QR pipeline. Runs N processing stages in a fixed order:

---
 rtl/qr_pkg.sv | 34 +++
 rtl/qr_ram_port_mux.sv | 55 +++++
 rtl/qr_stage_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/qr_pkg.sv
// Shared constants and types for the QR pipeline sequencer and its RAM port mux.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package qr_pkg;

  // Image BRAM data width and the stage-index / timeout-counter widths
  localparam int IMG_DW = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 24;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_END,
    ST_RELEASE,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Pipeline stage indices in run order; binarise always runs first
  typedef enum logic [IDX_W-1:0] {
    STG_BINARISE = 3'd0,
    STG_LOCATE   = 3'd1,
    STG_SAMPLE   = 3'd2,
    STG_DECODE   = 3'd3
  } stage_id_t;

  // Saturating increment: a stuck counter must never wrap back below the limit
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/qr_ram_port_mux.sv
// N-way registered mux from the per-stage image buses onto BRAM port B.
// Latency: 1 cycle from a stage's bus to web/dinb/addrb.
// Backpressure: none; web is forced low whenever no stage holds a valid grant.
module qr_ram_port_mux
  import qr_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    grant_vld,
  input  logic [IDX_W-1:0]        grant_idx,
  input  logic [N-1:0]            st_web,
  input  logic [IMG_DW*N-1:0]     st_dinb,
  input  logic [ADDR_WIDTH*N-1:0] st_addrb,
  output logic                    web,
  output logic [IMG_DW-1:0]       dinb,
  output logic [ADDR_WIDTH-1:0]   addrb
);

  logic                  sel_web;
  logic [IMG_DW-1:0]     sel_dinb;
  logic [ADDR_WIDTH-1:0] sel_addrb;

  // Pick the granted stage's bus; an out-of-range index selects nothing
  always_comb begin
    sel_web   = 1'b0;
    sel_dinb  = '0;
    sel_addrb = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_web   = st_web[i];
        sel_dinb  = st_dinb[IMG_DW*i +: IMG_DW];
        sel_addrb = st_addrb[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
    end
  end

  // Register the selection; without a grant, writes stop but address/data hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      web   <= 1'b0;
      dinb  <= '0;
      addrb <= '0;
    end else if (grant_vld) begin
      web   <= sel_web;
      dinb  <= sel_dinb;
      addrb <= sel_addrb;
    end else begin
      web   <= 1'b0;
    end
  end

endmodule

// File: rtl/qr_stage_sequencer.sv
// Runs the QR stages in order over the dmn_en/dmn_end handshake and owns BRAM port B.
// Latency: en one cycle after start; BRAM bus one cycle behind the active stage's bus.
// Backpressure: a stage holds the pipeline until it raises then drops end, or times out.
module qr_stage_sequencer
  import qr_pkg::*;
#(
  parameter int               N_STAGE    = 4,
  parameter int               ADDR_WIDTH = 18,
  parameter logic [CNT_W-1:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [IDX_W-1:0]              stage_idx,
  output logic [N_STAGE-1:0]            stage_en,
  input  logic [N_STAGE-1:0]            stage_end,
  input  logic [N_STAGE-1:0]            st_web,
  input  logic [IMG_DW*N_STAGE-1:0]     st_dinb,
  input  logic [ADDR_WIDTH*N_STAGE-1:0] st_addrb,
  output logic                          web,
  output logic [IMG_DW-1:0]             dinb,
  output logic [ADDR_WIDTH-1:0]         addrb,
  input  logic [IMG_DW-1:0]             doutb,
  output logic [IMG_DW-1:0]             st_doutb
);

  // The last WAIT_END cycle is the one whose incremented count hits TIMEOUT-1,
  // so a silent stage sees en for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_STAGE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_inc;
  logic             cur_end;
  logic             grant_act;
  logic             idx_clr, idx_inc;
  logic             err_set, err_clr;
  logic             cnt_clr, cnt_step;

  assign tmo_inc   = sat_inc(tmo_cnt);
  assign grant_act = (state == ST_ASSERT) || (state == ST_WAIT_END);
  assign busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign done      = (state == ST_FIN);
  assign st_doutb  = doutb;

  // One-hot enable for the active stage, and its end flag; other stages' end bits are ignored
  always_comb begin
    stage_en = '0;
    cur_end  = 1'b0;
    for (int i = 0; i < N_STAGE; i++) begin
      if (stage_idx == IDX_W'(i)) begin
        stage_en[i] = grant_act;
        cur_end     = stage_end[i];
      end
    end
  end

  // Next-state and side-effect decode; abort overrides everything and touches no status
  always_comb begin
    state_nxt = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_clr   = 1'b1;
          err_clr   = 1'b1;
          state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        cnt_step = 1'b1;
        // end is checked first so a simultaneous end and timeout completes cleanly
        if (cur_end) begin
          state_nxt = ST_RELEASE;
        end else if (tmo_inc == TIMEOUT_M1) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!cur_end) begin
          state_nxt = (stage_idx == LAST_IDX) ? ST_FIN : ST_NEXT;
        end
      end
      ST_NEXT: begin
        idx_inc   = 1'b1;
        state_nxt = ST_ASSERT;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_step  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage index, sticky error flag and saturating timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_idx <= '0;
      error     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (idx_clr) begin
        stage_idx <= STG_BINARISE;
      end else if (idx_inc) begin
        stage_idx <= stage_idx + 1'b1;
      end
      if (err_clr) begin
        error <= 1'b0;
      end else if (err_set) begin
        error <= 1'b1;
      end
      if (cnt_clr) begin
        tmo_cnt <= '0;
      end else if (cnt_step) begin
        tmo_cnt <= tmo_inc;
      end
    end
  end

  // abort gates the grant so no write slips through on the abort cycle
  qr_ram_port_mux #(
    .N          (N_STAGE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_vld (grant_act & ~abort),
    .grant_idx (stage_idx),
    .st_web    (st_web),
    .st_dinb   (st_dinb),
    .st_addrb  (st_addrb),
    .web       (web),
    .dinb      (dinb),
    .addrb     (addrb)
  );

endmodule
